mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-port RAM arbiter/sequencer between the instruction cache fill port (iREN/iaddr) and the data cache port (dREN/dWEN/daddr/dstore).
- Grants one requester at a time and drives the RAM.
- Returns per-requester wait/load.
- Data accesses have priority; a starvation counter forces an instruction grant after a bounded run of data grants.

Parameters:
- WORD_W, 32, data word width.
- ADDR_W, 32, byte address width.
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request is pending before the instruction port is forced.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache fill read request, held until iwait low
- iaddr  in  ADDR_W  icache fill address
- iwait  out  1  icache stall; low for exactly the completion cycle
- iload  out  WORD_W  fill data, valid when iREN && !iwait
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  WORD_W  dcache write data
- dwait  out  1  dcache stall; low for exactly the completion cycle
- dload  out  WORD_W  read data, valid when dREN && !dwait
- ram_ren  out  1  RAM read enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  WORD_W  RAM write data
- ram_load  in  WORD_W  RAM read data
- ram_state  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- FSM states: IDLE, IGRANT, DGRANT (state register only; RAM outputs are combinational from state and the granted requester's live inputs).
- Reset: state=IDLE, starve_cnt=0. All ram_* outputs are 0; iload/dload are 0.
- Wait outputs, including during reset: iwait = iREN && !(state==IGRANT && ram_state==ACCESS); dwait = (dREN||dWEN) && !(state==DGRANT && ram_state==ACCESS).
- IDLE transitions:
  - If (dREN||dWEN) && !(iREN && starve_cnt==STARVE_LIMIT), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
  - No RAM enable is asserted in IDLE; minimum latency is therefore 2 cycles (grant cycle, then the earliest ACCESS).
- IGRANT outputs: ram_ren=1, ram_addr=iaddr, ram_wen=0, ram_store=0, iload=ram_load.
- DGRANT outputs: ram_addr=daddr.
  - dWEN has precedence over dREN: if dWEN, ram_wen=1, ram_ren=0, ram_store=dstore.
  - Else ram_ren=1 and dload=ram_load.
- Exit from a grant state to IDLE happens on the cycle after ram_state==ACCESS, or immediately on the next edge if the granted request deasserts. Example: icache abort on PC reset drops iREN; the arbiter returns to IDLE with no wait pulse and the RAM enables drop the same cycle.
- ram_state BUSY or FREE while granted: hold the grant and keep driving.
- ram_state ERROR while granted: hold the grant and keep driving (retry); the wait stays high.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on each data completion while iREN is high, saturating at STARVE_LIMIT.
  - Clears on any instruction completion, or whenever iREN is low.
- Back-to-back requests: a requester still asserting after completion is re-arbitrated from IDLE; there is no bypass of IDLE.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_LIMIT: data wins, and instruction is served next.
- Asynchronous reset mid-grant: the grant aborts immediately; the RAM enables drop asynchronously.

Decomposition:
- Shared package (cpu_types_pkg): word_t, ramstate_t enum (FREE/BUSY/ACCESS/ERROR), arb_state_t enum (IDLE/IGRANT/DGRANT).
- No sub-module; the starvation counter is inline.

Test Plan:
- Data read: dREN=1, daddr=0x40, RAM returns ACCESS 3 cycles after the grant with ram_load=0xDEADBEEF -> ram_ren=1, ram_addr=0x40. dwait low for exactly 1 cycle with dload=0xDEADBEEF. iwait unaffected.
- Simultaneous iREN (iaddr=0x100) and dWEN (daddr=0x200, dstore=0x12345678) -> ram_wen/0x200/0x12345678 first. After dwait drops, IDLE, then ram_ren with 0x100.
- Starvation, STARVE_LIMIT=4: iREN held high while dREN is re-asserted continuously -> exactly 4 data completions, then an instruction grant. starve_cnt=0 after the iwait pulse.
- Abort: iREN=1 in IGRANT with ram_state=BUSY, then iREN dropped -> the next cycle is IDLE with ram_ren=0. No iwait low pulse. A pending dREN is granted the cycle after.
- ERROR retry: DGRANT read receives ram_state ERROR for 2 cycles, then ACCESS -> address is held stable throughout and dwait stays high until the ACCESS cycle.
- Reset mid-grant: nRST low during DGRANT write -> ram_wen=0 immediately. After release, state is IDLE and starve_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word, RAM handshake state and
// arbiter grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache fill port and the dcache port.
// Data has priority; a starvation counter forces an instruction grant.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic [1:0]        ram_state
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic dreq;
  logic access;
  logic i_done;
  logic d_done;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate_t'(ram_state) == ACCESS);
  assign i_done = (state_q == IGRANT) & access;
  assign d_done = (state_q == DGRANT) & access;
  assign iwait  = iREN & ~i_done;
  assign dwait  = dreq & ~d_done;

  // Grant sequencing: every completion or abort passes back through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dreq && !(iREN && (starve_q == LIMIT))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || access) begin
          state_d = IDLE;
        end else begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!dreq || access) begin
          state_d = IDLE;
        end else begin
          state_d = DGRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts data completions that overtook a waiting instruction fetch.
  always_comb begin
    starve_d = starve_q;
    if (!iREN || i_done) begin
      starve_d = '0;
    end else if (d_done && dreq && (starve_q != LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // RAM drive follows the granted requester's live inputs, so an abort
  // removes the enables without waiting for the state register.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iload     = '0;
    dload     = '0;
    case (state_q)
      IGRANT: begin
        if (iREN) begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          iload    = ram_load;
        end else begin
          ram_ren  = 1'b0;
        end
      end
      DGRANT: begin
        if (dWEN) begin
          ram_wen   = 1'b1;
          ram_addr  = daddr;
          ram_store = dstore;
        end else if (dREN) begin
          ram_ren  = 1'b1;
          ram_addr = daddr;
          dload    = ram_load;
        end else begin
          ram_ren  = 1'b0;
        end
      end
      default: ram_ren = 1'b0;
    endcase
  end

endmodule
